// File: rtl/fifo_ctl_if.sv
// Control/status bundle between fifo_ctl (slave) and its producer/consumer side (master).
// AFULLO is present only when FIFO_CTL_AFULL_EN is defined.
interface fifo_ctl_if #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
);
  logic             PUSHI;
  logic             POPI;
  logic             FLUSHI;
  logic             DRAINI;
  logic [DEPTH-1:0] CTLHITI;
  logic [DEPTH-1:0] VALIDO;
  logic             SHIFTO;
  logic             PUSHACKO;
  logic             FULLO;
  logic             EMPTYO;
  logic [CNTW-1:0]  COUNTO;
  logic             HITO;
  logic             DRAINDONEO;
`ifdef FIFO_CTL_AFULL_EN
  logic             AFULLO;
`endif

  modport master (
`ifdef FIFO_CTL_AFULL_EN
    input  AFULLO,
`endif
    output PUSHI, POPI, FLUSHI, DRAINI, CTLHITI,
    input  VALIDO, SHIFTO, PUSHACKO, FULLO, EMPTYO, COUNTO, HITO, DRAINDONEO
  );

  modport slave (
`ifdef FIFO_CTL_AFULL_EN
    output AFULLO,
`endif
    input  PUSHI, POPI, FLUSHI, DRAINI, CTLHITI,
    output VALIDO, SHIFTO, PUSHACKO, FULLO, EMPTYO, COUNTO, HITO, DRAINDONEO
  );
endinterface

// File: rtl/fifo_ctl.sv
// Occupancy/valid control for a shift-register FIFO datapath, with drain handshake.
// Optional registered almost-full output AFULLO when FIFO_CTL_AFULL_EN is defined.
module fifo_ctl #(
  parameter int DEPTH = 4,
  parameter int CNTW  = 3
) (
  input logic       CLOCKI,
  input logic       RESETI,
  fifo_ctl_if.slave bus
);

  typedef enum logic {
    NORMAL = 1'b0,
    DRAIN  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] valid_next;
  logic [CNTW-1:0]  count;
  logic [CNTW-1:0]  count_next;
  logic             full;
  logic             empty;
  logic             shift;
  logic             push_ok;
  logic             drain_done;
`ifdef FIFO_CTL_AFULL_EN
  logic             afull;
`endif

  // A full FIFO rejects pushes even when a pop frees the head this cycle.
  assign shift   = bus.POPI & valid[0];
  assign push_ok = bus.PUSHI & ~full & ~bus.FLUSHI & (state == NORMAL);

  always_comb begin
    valid_next = valid;
    count_next = count;
    if (bus.FLUSHI) begin
      valid_next = '0;
      count_next = '0;
    end else if (push_ok && !shift) begin
      valid_next = {valid[DEPTH-2:0], 1'b1};
      count_next = count + CNTW'(1);
    end else if (shift && !push_ok) begin
      valid_next = valid >> 1;
      count_next = count - CNTW'(1);
    end
  end

  // Drain completes the first cycle the registered count is zero; reset suppresses the pulse.
  always_comb begin
    state_next = state;
    drain_done = 1'b0;
    case (state)
      NORMAL: begin
        if (bus.DRAINI) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (count == '0) begin
          state_next = NORMAL;
          drain_done = ~RESETI;
        end
      end
      default: state_next = NORMAL;
    endcase
  end

  always_ff @(posedge CLOCKI) begin
    if (RESETI) begin
      state <= NORMAL;
      valid <= '0;
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
`ifdef FIFO_CTL_AFULL_EN
      afull <= 1'b0;
`endif
    end else begin
      state <= state_next;
      valid <= valid_next;
      count <= count_next;
      full  <= (count_next == CNTW'(DEPTH));
      empty <= (count_next == '0);
`ifdef FIFO_CTL_AFULL_EN
      afull <= (count_next >= CNTW'(DEPTH - 1));
`endif
    end
  end

  assign bus.VALIDO     = valid;
  assign bus.SHIFTO     = shift;
  assign bus.PUSHACKO   = push_ok;
  assign bus.FULLO      = full;
  assign bus.EMPTYO     = empty;
  assign bus.COUNTO     = count;
  assign bus.HITO       = |(bus.CTLHITI & valid);
  assign bus.DRAINDONEO = drain_done;
`ifdef FIFO_CTL_AFULL_EN
  assign bus.AFULLO     = afull;
`endif

endmodule

// File: tb/tb_fifo_ctl.sv
// Self-checking bench for fifo_ctl: directed scenarios plus random traffic against an occupancy model.
// Exercises AFULLO as well when FIFO_CTL_AFULL_EN is defined.
module tb_fifo_ctl;
  localparam int DEPTH = 4;
  localparam int CNTW  = 3;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  fifo_ctl_if #(.DEPTH(DEPTH), .CNTW(CNTW)) bus ();

  fifo_ctl #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
    .CLOCKI (clock),
    .RESETI (reset),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: occupancy as an integer, drain mode as a flag.
  int occ         = 0;
  bit draining    = 1'b0;
  bit afull_model = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  function automatic logic [DEPTH-1:0] thermo(input int n);
    logic [DEPTH-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  // One clock of stimulus: drive at negedge, compare every output, then advance the model at posedge.
  task automatic applyStimulus(input bit push, input bit pop, input bit flush, input bit drain,
                               input bit rst, input logic [DEPTH-1:0] hit);
    bit exp_shift;
    bit exp_ack;
    bit exp_done;
    @(negedge clock);
    bus.PUSHI   = push;
    bus.POPI    = pop;
    bus.FLUSHI  = flush;
    bus.DRAINI  = drain;
    bus.CTLHITI = hit;
    reset       = rst;
    #1;
    exp_shift = pop && (occ > 0);
    exp_ack   = push && (occ < DEPTH) && !flush && !draining;
    exp_done  = draining && (occ == 0) && !rst;
    checkOutput("valid",     bus.VALIDO,     thermo(occ));
    checkOutput("count",     bus.COUNTO,     occ);
    checkOutput("full",      bus.FULLO,      occ == DEPTH);
    checkOutput("empty",     bus.EMPTYO,     occ == 0);
    checkOutput("shift",     bus.SHIFTO,     exp_shift);
    checkOutput("pushack",   bus.PUSHACKO,   exp_ack);
    checkOutput("hit",       bus.HITO,       |(hit & thermo(occ)));
    checkOutput("drainDone", bus.DRAINDONEO, exp_done);
`ifdef FIFO_CTL_AFULL_EN
    checkOutput("afull",     bus.AFULLO,     afull_model);
`endif
    @(posedge clock);
    if (rst) begin
      occ         = 0;
      draining    = 1'b0;
      afull_model = 1'b0;
    end else begin
      if (draining && occ == 0) draining = 1'b0;
      else if (!draining && drain) draining = 1'b1;
      if (flush) occ = 0;
      else occ = occ + int'(exp_ack) - int'(exp_shift);
      afull_model = (occ >= DEPTH - 1);
    end
  endtask

  initial begin
    logic [DEPTH-1:0] push_seq [4];
    push_seq[0] = 4'b0001;
    push_seq[1] = 4'b0011;
    push_seq[2] = 4'b0111;
    push_seq[3] = 4'b1111;

    bus.PUSHI   = 1'b0;
    bus.POPI    = 1'b0;
    bus.FLUSHI  = 1'b0;
    bus.DRAINI  = 1'b0;
    bus.CTLHITI = '0;
    reset       = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rstValid", bus.VALIDO, 0);
    checkOutput("rstCount", bus.COUNTO, 0);
    checkOutput("rstFull",  bus.FULLO,  0);
    checkOutput("rstEmpty", bus.EMPTYO, 1);
    checkOutput("rstDone",  bus.DRAINDONEO, 0);

    // Fill to full, one thermometer step per push, then a rejected fifth push
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1, 0, 0, 0, 0, '0);
      #1;
      checkOutput("fillValid", bus.VALIDO, push_seq[i]);
    end
    checkOutput("fillFull", bus.FULLO, 1);
    applyStimulus(1, 0, 0, 0, 0, '0);

    // Push+pop while full: pop wins, push rejected
    applyStimulus(1, 1, 0, 0, 0, '0);
    #1;
    checkOutput("fullPushPopCount", bus.COUNTO, 3);
    checkOutput("fullPushPopValid", bus.VALIDO, 4'b0111);

    // Simultaneous push+pop at count 2 holds, then empty and pop on empty
    applyStimulus(0, 1, 0, 0, 0, '0);
    applyStimulus(1, 1, 0, 0, 0, '0);
    #1;
    checkOutput("pushPopHold", bus.VALIDO, 4'b0011);
    applyStimulus(0, 1, 0, 0, 0, '0);
    applyStimulus(0, 1, 0, 0, 0, '0);
    applyStimulus(0, 1, 0, 0, 0, '0);

    // Hits on invalid entries ignored; flush beats push
    applyStimulus(1, 0, 0, 0, 0, '0);
    applyStimulus(1, 0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 0, 0, 4'b1100);
    applyStimulus(0, 0, 0, 0, 0, 4'b0010);
    applyStimulus(1, 0, 1, 0, 0, '0);
    #1;
    checkOutput("flushCount", bus.COUNTO, 0);

    // Drain from count 3 with pushes held high; a second DRAINI mid-drain is ignored
    repeat (3) applyStimulus(1, 0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 1, 0, '0);
    applyStimulus(1, 1, 0, 1, 0, '0);
    repeat (3) applyStimulus(1, 1, 0, 0, 0, '0);
    repeat (2) applyStimulus(1, 0, 0, 0, 0, '0);

    // Drain requested while already empty
    applyStimulus(0, 0, 1, 0, 0, '0);
    applyStimulus(0, 0, 0, 1, 0, '0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, '0);

    // Flush during drain
    repeat (2) applyStimulus(1, 0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 1, 0, '0);
    applyStimulus(0, 0, 1, 0, 0, '0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, '0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      applyStimulus($urandom_range(9) < 6, $urandom_range(1) == 1, $urandom_range(31) == 0,
                    $urandom_range(15) == 0, $urandom_range(63) == 0, DEPTH'($urandom));
    end

    // Reset in the middle of a drain aborts it silently
    applyStimulus(0, 0, 1, 0, 0, '0);
    repeat (3) applyStimulus(1, 0, 0, 0, 0, '0);
    applyStimulus(0, 0, 0, 1, 0, '0);
    applyStimulus(1, 1, 0, 0, 0, '0);
    applyStimulus(1, 0, 0, 0, 1, '0);
    #1;
    checkOutput("midDrainRstCount", bus.COUNTO, 0);
    checkOutput("midDrainRstEmpty", bus.EMPTYO, 1);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL timeout: observed no finish expected finish");
    $fatal(1, "[TB] timeout");
  end
endmodule

// File: doc/fifo_ctl.md
FIFO_CTL -- requirements
Module: fifo_ctl

Interface
REQ-001 Parameter DEPTH, default 4: number of FIFO entries; legal range 2..7.
REQ-002 Parameter CNTW, default 3: width of COUNTO; SHALL satisfy 2^CNTW > DEPTH.
REQ-003 CLOCKI  input  1  sole clock; all state SHALL update on its rising edge.
REQ-004 RESETI  input  1  reset; synchronous, active-high.
REQ-005 PUSHI  input  1  producer requests one entry write; the datapath captures DATAI this cycle.
REQ-006 POPI  input  1  consumer takes the head entry this cycle.
REQ-007 FLUSHI  input  1  discard all entries.
REQ-008 DRAINI  input  1  one-cycle request: block pushes until the FIFO is empty.
REQ-009 CTLHITI  input  DEPTH  per-entry compare hits from the datapath.
REQ-010 VALIDO  output  DEPTH  thermometer valid vector; drives the datapath load/valid control.
REQ-011 SHIFTO  output  1  shift command to the datapath.
REQ-012 PUSHACKO  output  1  push accepted this cycle.
REQ-013 FULLO, EMPTYO  output  1 each  registered status.
REQ-014 COUNTO  output  CNTW  registered occupancy.
REQ-015 HITO  output  1  some valid entry matches the compare.
REQ-016 DRAINDONEO  output  1  one-cycle pulse when a drain completes.

Function
REQ-017 VALIDO SHALL always be thermometer-coded: bits [COUNTO-1:0] are set and the remaining bits are clear.
REQ-018 SHIFTO SHALL equal POPI & VALIDO[0]; a pop when empty is ignored.
REQ-019 PUSHACKO SHALL equal PUSHI & !FULLO & !FLUSHI & (state==NORMAL).
REQ-020 A push is rejected when full even if a pop occurs in the same cycle; the datapath top entry cannot load during a shift.
REQ-021 Next VALIDO: for push only, {VALIDO[DEPTH-2:0],1}; for pop only, VALIDO>>1; for push and pop together, unchanged; otherwise held.
REQ-022 COUNTO SHALL track VALIDO.
REQ-023 FULLO SHALL be set iff the count is DEPTH.
REQ-024 EMPTYO SHALL be set iff the count is 0.
REQ-025 All status outputs SHALL be valid in the cycle after the event that caused them, i.e. latency 1.
REQ-026 FLUSHI SHALL set VALIDO, COUNTO and FULLO to 0 and EMPTYO to 1 on the next edge.
REQ-027 FLUSHI overrides push and pop; SHIFTO still follows REQ-018 in the flush cycle.
REQ-028 HITO SHALL equal |(CTLHITI & VALIDO), combinationally; hits on invalid entries are ignored.
REQ-029 FSM states: NORMAL and DRAIN.
REQ-030 NORMAL -> DRAIN on DRAINI.
REQ-031 DRAIN -> NORMAL when the registered count is 0; DRAINDONEO SHALL be 1 for exactly that one cycle.
REQ-032 DRAINI asserted while the FIFO is already empty SHALL enter DRAIN and then pulse DRAINDONEO on the following cycle.
REQ-033 DRAINI asserted while in DRAIN SHALL be ignored.
REQ-034 A flush during DRAIN SHALL lead to DRAINDONEO one cycle after the count becomes 0.
REQ-035 Priority order: RESETI, then FLUSHI, then push/pop.

Reset
REQ-036 While RESETI is high at an edge: VALIDO=0, COUNTO=0, FULLO=0, EMPTYO=1, DRAINDONEO=0, state=NORMAL, AFULLO=0 if present.
REQ-037 Reset mid-drain SHALL abort the drain without a DRAINDONEO pulse.
REQ-038 Pushes asserted in the reset cycle are lost; PUSHACKO is not forced low in that cycle.

Configuration
REQ-039 Macro FIFO_CTL_AFULL_EN defined: the module SHALL add output AFULLO (1 bit), registered.
REQ-040 AFULLO SHALL be set when the next count is at least DEPTH-1.
REQ-041 Macro FIFO_CTL_AFULL_EN undefined: the AFULLO port and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-042 DEPTH=4, reset, then 4 consecutive pushes -> VALIDO 0001,0011,0111,1111; FULLO=1 after the 4th; a 5th push gives PUSHACKO=0.
REQ-043 Full, PUSHI=1 and POPI=1 together -> SHIFTO=1, PUSHACKO=0, next COUNTO=3, VALIDO=0111.
REQ-044 COUNTO=2, push and pop together -> VALIDO stays 0011; pop at COUNTO=0 -> SHIFTO=0, state unchanged.
REQ-045 COUNTO=3, DRAINI, then one pop per cycle with PUSHI held high -> no PUSHACKO; DRAINDONEO pulses once, the cycle after COUNTO reaches 0.
REQ-046 COUNTO=2 with CTLHITI=1100 -> HITO=0; with CTLHITI=0010 -> HITO=1; then FLUSHI together with PUSHI -> next COUNTO=0, PUSHACKO=0.
REQ-047 Run with FIFO_CTL_AFULL_EN defined: AFULLO rises with COUNTO=3 and falls at COUNTO=2; RESETI asserted mid-drain -> all outputs at reset values and no DRAINDONEO.
